// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_pkg : source-select and load-size encodings for the writeback datapath  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wb_pkg;

    localparam logic [1:0] SRC_RESULT = 2'd0;
    localparam logic [1:0] SRC_LOAD   = 2'd1;
    localparam logic [1:0] SRC_LINK   = 2'd2;
    localparam logic [1:0] SRC_RSVD   = 2'd3;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/writeback_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_align : extracts and extends a sub-width load lane, flags bad access  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] readData,
    input  logic [1:0]        memSize,
    input  logic              memSigned,
    input  logic [LANE_W-1:0] addrLow,
    output logic [DATA_W-1:0] alignedData,
    output logic              illegal
);

    logic [LANE_W-1:0] w_lane;
    logic [DATA_W-1:0] w_sh;

    // Wider accesses take the lane rounded down to their natural boundary.
    always_comb begin
        w_lane = '0;
        case (memSize)
            SIZE_BYTE: w_lane = addrLow;
            SIZE_HALF: w_lane = addrLow & ~LANE_W'(1);
            SIZE_WORD: w_lane = addrLow & ~LANE_W'(3);
            default:   w_lane = '0;
        endcase
    end

    assign w_sh = readData >> {w_lane, 3'b000};

    always_comb begin
        alignedData = '0;
        illegal     = 1'b0;
        case (memSize)
            SIZE_BYTE: begin
                if (memSigned) alignedData = DATA_W'($signed(w_sh[7:0]));
                else           alignedData = DATA_W'(w_sh[7:0]);
            end
            SIZE_HALF: begin
                illegal = addrLow[0];
                if (memSigned) alignedData = DATA_W'($signed(w_sh[15:0]));
                else           alignedData = DATA_W'(w_sh[15:0]);
            end
            SIZE_WORD: begin
                illegal = (addrLow[1:0] != 2'b00);
                if (memSigned) alignedData = DATA_W'($signed(w_sh[31:0]));
                else           alignedData = DATA_W'(w_sh[31:0]);
            end
            default: begin
                illegal     = (DATA_W != 64) || (addrLow != '0);
                alignedData = w_sh;
            end
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_stage : registered MEM/WB stage driving the register-file port   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      regWriteIn,
    input  logic [REG_ADDR_W-1:0]     destIn,
    input  logic [1:0]                srcSel,
    input  logic [1:0]                memSize,
    input  logic                      memSigned,
    input  logic [$clog2(DATA_W/8)-1:0] addrLow,
    input  logic [DATA_W-1:0]         result,
    input  logic [DATA_W-1:0]         readData,
    input  logic [DATA_W-1:0]         linkAddr,
    output logic                      wbValid,
    output logic                      regWrite,
    output logic [REG_ADDR_W-1:0]     writeReg,
    output logic [DATA_W-1:0]         writeData,
    output logic                      misalign,
    output logic [31:0]               retireCount
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    logic [DATA_W-1:0]     w_aligned;
    logic                  w_load_illegal;
    logic [DATA_W-1:0]     w_data;
    logic                  w_legal;
    logic                  w_misalign;
    logic                  w_reg_write;

    logic                  r_wb_valid;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;
    logic                  r_misalign;
    logic [31:0]           r_retire_count;

    load_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_load_align (
        .readData    (readData),
        .memSize     (memSize),
        .memSigned   (memSigned),
        .addrLow     (addrLow),
        .alignedData (w_aligned),
        .illegal     (w_load_illegal)
    );

    // Illegal loads and the reserved source both write zero with the enable dropped.
    always_comb begin
        w_data     = '0;
        w_legal    = 1'b1;
        w_misalign = 1'b0;
        case (srcSel)
            SRC_RESULT: w_data = result;
            SRC_LOAD: begin
                if (w_load_illegal) begin
                    w_legal    = 1'b0;
                    w_misalign = 1'b1;
                end else begin
                    w_data = w_aligned;
                end
            end
            SRC_LINK:   w_data = linkAddr;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_reg_write = regWriteIn && w_legal && !((ZERO_REG != 0) && (destIn == '0));
    assign inReady     = !stall;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wb_valid     <= 1'b0;
            r_reg_write    <= 1'b0;
            r_write_reg    <= '0;
            r_write_data   <= '0;
            r_misalign     <= 1'b0;
            r_retire_count <= '0;
        end else begin
            // One count per instruction leaving the stage, whether drained or squashed.
            if (r_wb_valid && (!stall || flush)) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
            if (flush || (!stall && !inValid)) begin
                r_wb_valid  <= 1'b0;
                r_reg_write <= 1'b0;
                r_misalign  <= 1'b0;
            end else if (!stall) begin
                r_wb_valid   <= 1'b1;
                r_reg_write  <= w_reg_write;
                r_write_reg  <= destIn;
                r_write_data <= w_data;
                r_misalign   <= w_misalign;
            end
        end
    end

    assign wbValid     = r_wb_valid;
    assign regWrite    = r_reg_write;
    assign writeReg    = r_write_reg;
    assign writeData   = r_write_data;
    assign misalign    = r_misalign;
    assign retireCount = r_retire_count;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_stage : directed and random checks against a behavioural model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_writeback_stage;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic        stall;
    logic        flush;
    logic        regWriteIn;
    logic [4:0]  destIn;
    logic [1:0]  srcSel;
    logic [1:0]  memSize;
    logic        memSigned;
    logic [1:0]  addrLow;
    logic [31:0] result;
    logic [31:0] readData;
    logic [31:0] linkAddr;
    logic        wbValid;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        misalign;
    logic [31:0] retireCount;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the write port should show after each edge.
    logic        m_valid;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_mis;
    logic [31:0] m_count;

    writeback_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .inValid     (inValid),
        .inReady     (inReady),
        .stall       (stall),
        .flush       (flush),
        .regWriteIn  (regWriteIn),
        .destIn      (destIn),
        .srcSel      (srcSel),
        .memSize     (memSize),
        .memSigned   (memSigned),
        .addrLow     (addrLow),
        .result      (result),
        .readData    (readData),
        .linkAddr    (linkAddr),
        .wbValid     (wbValid),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .misalign    (misalign),
        .retireCount (retireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("inReady",     32'(inReady),     32'(!stall));
        chk("wbValid",     32'(wbValid),     32'(m_valid));
        chk("regWrite",    32'(regWrite),    32'(m_we));
        chk("writeReg",    32'(writeReg),    32'(m_reg));
        chk("writeData",   writeData,        m_data);
        chk("misalign",    32'(misalign),    32'(m_mis));
        chk("retireCount", retireCount,      m_count);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_reg = '0; m_data = '0; m_mis = 1'b0; m_count = '0;
    endtask

    // What the instruction currently presented would write, from the load rules directly.
    task automatic model_compute(output logic [31:0] d, output logic we, output logic mis);
        int unsigned     nbytes;
        int unsigned     bits;
        longint unsigned v;
        logic            legal;
        d = '0; mis = 1'b0; legal = 1'b1;
        case (srcSel)
            2'd0: d = result;
            2'd2: d = linkAddr;
            2'd3: legal = 1'b0;
            default: begin
                nbytes = 1 << memSize;
                if (nbytes > 4 || (int'(addrLow) % nbytes) != 0) begin
                    mis = 1'b1;
                    legal = 1'b0;
                end else begin
                    bits = 8 * nbytes;
                    v = (64'(readData) >> (8 * addrLow)) & ((64'd1 << bits) - 64'd1);
                    if (memSigned && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
                    d = v[31:0];
                end
            end
        endcase
        we = regWriteIn && legal && (destIn != 5'd0);
    endtask

    task automatic model_edge();
        logic [31:0] d;
        logic        we;
        logic        mis;
        model_compute(d, we, mis);
        if (m_valid && (!stall || flush)) m_count = m_count + 32'd1;
        if (flush || (!stall && !inValid)) begin
            m_valid = 1'b0; m_we = 1'b0; m_mis = 1'b0;
        end else if (!stall) begin
            m_valid = 1'b1; m_we = we; m_reg = destIn; m_data = d; m_mis = mis;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [1:0] sz,
                         input logic sg, input logic [1:0] al, input logic [4:0] dst);
        inValid = v; srcSel = src; memSize = sz; memSigned = sg; addrLow = al;
        destIn = dst; regWriteIn = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [31:0] cnt0;
        rstN = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 5'd0);
        result = '0; readData = '0; linkAddr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstN = 1'b1;

        // Signed byte from lane 1.
        drive(1'b1, 2'd1, 2'd0, 1'b1, 2'd1, 5'd4);
        readData = 32'h1234_8678;
        cycle();
        chk("lb_data", writeData, 32'hFFFF_FF86);
        chk("lb_reg",  32'(writeReg), 32'd4);
        chk("lb_we",   32'(regWrite), 32'd1);

        // Unsigned half, aligned then misaligned.
        drive(1'b1, 2'd1, 2'd1, 1'b0, 2'd2, 5'd5);
        cycle();
        chk("lhu_data", writeData, 32'h0000_1234);
        drive(1'b1, 2'd1, 2'd1, 1'b0, 2'd3, 5'd5);
        cycle();
        chk("lhu_mis",  32'(misalign), 32'd1);
        chk("lhu_we",   32'(regWrite), 32'd0);
        chk("lhu_zero", writeData, 32'h0);

        // Capture, stall three cycles, then squash while still stalled.
        drive(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 5'd7);
        result = 32'hA5;
        cycle();
        chk("alu_data", writeData, 32'hA5);
        cnt0 = m_count;
        stall = 1'b1;
        result = 32'h5A;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_data",  writeData, 32'hA5);
            chk("stall_count", retireCount, cnt0);
        end
        flush = 1'b1;
        cycle();
        chk("flush_valid", 32'(wbValid), 32'd0);
        chk("flush_count", retireCount, cnt0 + 32'd1);

        // Link write to x0 is suppressed but still carries data.
        drive(1'b1, 2'd2, 2'd3, 1'b0, 2'd3, 5'd0);
        linkAddr = 32'h40;
        cycle();
        chk("x0_we",    32'(regWrite), 32'd0);
        chk("x0_data",  writeData, 32'h40);
        chk("x0_valid", 32'(wbValid), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            inValid    = ($urandom_range(3) != 0);
            stall      = ($urandom_range(3) == 0);
            flush      = ($urandom_range(9) == 0);
            regWriteIn = ($urandom_range(7) != 0);
            destIn     = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
            srcSel     = 2'($urandom);
            memSize    = 2'($urandom);
            memSigned  = 1'($urandom);
            addrLow    = 2'($urandom);
            result     = $urandom;
            readData   = $urandom;
            linkAddr   = $urandom;
            cycle();
        end

        // Asynchronous reset mid-cycle while holding a valid instruction.
        drive(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 5'd9);
        result = 32'hDEAD_BEEF;
        cycle();
        chk("pre_rst_valid", 32'(wbValid), 32'd1);
        #3;
        rstN = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rstN = 1'b1;

        // Counter wrap from a preloaded value.
        inValid = 1'b0;
        cycle();
        #1;
        force dut.r_retire_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_retire_count;
        m_count = 32'hFFFF_FFFE;
        drive(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 5'd3);
        cycle();
        cycle();
        chk("wrap_pre", retireCount, 32'hFFFF_FFFF);
        inValid = 1'b0;
        cycle();
        chk("wrap_zero", retireCount, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire
